// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked frame, ACK check.
// Open-drain style: *_oe=1 pulls the pad low, 0 releases it to the pull-up.
module ps2_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int RW = $clog2(RTS_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state_q;
    logic                    d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0]   c_sh_q;
    logic                    c_filt_q, c_filt_d;
    logic                    fall_tick;
    logic [8:0]              sr_q;
    logic [3:0]              n_q;
    logic [RW-1:0]           rts_q;
    logic [TW-1:0]           tmo_q;
    logic                    c_oe_q, d_oe_q, idle_q, done_q, ack_q, to_q;
    logic                    active;
    logic                    tmo_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
            c_sh_q   <= '1;
            c_filt_q <= 1'b1;
        end else begin
            d_meta_q <= ps2d_in;
            d_sync_q <= d_meta_q;
            c_sh_q   <= {c_sh_q[FILTER_LEN-2:0], ps2c_in};
            c_filt_q <= c_filt_d;
        end
    end

    // Filtered clock only moves on a unanimous window, otherwise it holds.
    always_comb begin
        c_filt_d = c_filt_q;
        if (&c_sh_q)
            c_filt_d = 1'b1;
        else if (~|c_sh_q)
            c_filt_d = 1'b0;
    end

    assign fall_tick = c_filt_q & ~c_filt_d;
    assign active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign tmo_hit   = active && !fall_tick && (tmo_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            n_q     <= '0;
            rts_q   <= '0;
            tmo_q   <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active) begin
                if (fall_tick)
                    tmo_q <= TW'(TIMEOUT_CYCLES - 1);
                else if (tmo_q != '0)
                    tmo_q <= tmo_q - TW'(1);
            end
            if (tmo_hit) begin
                c_oe_q  <= 1'b0;
                d_oe_q  <= 1'b0;
                idle_q  <= 1'b1;
                done_q  <= 1'b1;
                ack_q   <= 1'b0;
                to_q    <= 1'b1;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (wr_ps2) begin
                            sr_q    <= {~^din, din};
                            rts_q   <= RW'(RTS_CYCLES - 1);
                            c_oe_q  <= 1'b1;
                            d_oe_q  <= 1'b0;
                            idle_q  <= 1'b0;
                            ack_q   <= 1'b0;
                            to_q    <= 1'b0;
                            state_q <= RTS;
                        end
                    end
                    RTS: begin
                        if (rts_q == '0) begin
                            c_oe_q  <= 1'b0;
                            d_oe_q  <= 1'b1;
                            tmo_q   <= TW'(TIMEOUT_CYCLES - 1);
                            state_q <= START;
                        end else begin
                            rts_q <= rts_q - RW'(1);
                        end
                    end
                    START: begin
                        if (fall_tick) begin
                            n_q     <= '0;
                            d_oe_q  <= ~sr_q[0];
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall_tick) begin
                            if (n_q == 4'd8) begin
                                d_oe_q  <= 1'b0;
                                state_q <= STOP;
                            end else begin
                                sr_q   <= sr_q >> 1;
                                n_q    <= n_q + 4'd1;
                                d_oe_q <= ~sr_q[1];
                            end
                        end
                    end
                    STOP: begin
                        if (fall_tick) begin
                            ack_q   <= d_sync_q;
                            done_q  <= 1'b1;
                            idle_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ps2c_oe      = c_oe_q;
    assign ps2d_oe      = d_oe_q;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign ack_err      = ack_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: device model on wired-AND pads, scoreboard of expected frames and status.
// Stimulus issues commands; a separate monitor checks each completed frame.
module tb_ps2_tx;

    localparam int RTS = 60;
    localparam int FL  = 4;
    localparam int TO  = 3000;
    localparam int HP  = 40;

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         to;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err;
    logic       bc = 1'b0;
    logic       bd = 1'b0;

    exp_t        exp_q[$];
    logic [10:0] obs_q[$];
    int          total = 0;
    int          passed = 0;
    int          rts_cnt = 0;
    bit          chk_pulse = 0;
    bit          last_ack = 0;

    assign ps2c_in = ~(ps2c_oe | bc);
    assign ps2d_in = ~(ps2d_oe | bd);

    always #5 clk = ~clk;

    ps2_tx #(
        .RTS_CYCLES(RTS),
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err(ack_err),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req)
            passed++;
        else
            $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic expire(input string name);
        total++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Wire order: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] fr;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            fr[i+1] = d[i];
        fr[9]  = ($countones(d) % 2 == 0);
        fr[10] = 1'b1;
        return fr;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [10:0] o;
        if (reset) begin
            rts_cnt   = 0;
            chk_pulse = 0;
        end else begin
            if (chk_pulse) begin
                chk("done_pulse_width", int'(tx_done_tick), 0);
                chk_pulse = 0;
            end
            if (ps2c_oe) begin
                rts_cnt++;
            end else if (rts_cnt != 0) begin
                chk("rts_len", rts_cnt, RTS);
                rts_cnt = 0;
            end
            if (tx_done_tick) begin
                chk_pulse = 1;
                if (exp_q.size() == 0) begin
                    expire("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_err", int'(ack_err), int'(e.ack));
                    chk("timeout_err", int'(timeout_err), int'(e.to));
                    chk("idle_at_done", int'(tx_idle), 1);
                    if (!e.to) begin
                        if (obs_q.size() == 0) begin
                            expire("frame_missing");
                        end else begin
                            o = obs_q.pop_front();
                            chk("frame", int'(o), int'(frame_of(e.d)));
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d, input bit ack, input bit to);
        exp_t e;
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        e.d    = d;
        e.ack  = ack;
        e.to   = to;
        exp_q.push_back(e);
        last_ack = ack;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic device(input bit ack_low, input int glitch_k,
                          input int abort_k, input int wr_k);
        logic [10:0] b;
        int w;
        w = 0;
        while (ps2c_in && w < RTS * 4) begin
            @(negedge clk);
            w++;
        end
        w = 0;
        while (!(ps2c_in && !ps2d_in) && w < RTS * 4) begin
            @(negedge clk);
            w++;
        end
        if (w >= RTS * 4) begin
            expire("start_bit");
            return;
        end
        b[0] = ps2d_in;
        for (int k = 1; k <= 10; k++) begin
            repeat (HP) @(negedge clk);
            bc = 1'b1;
            repeat (HP) @(negedge clk);
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_c_oe", int'(ps2c_oe), 0);
                chk("rst_d_oe", int'(ps2d_oe), 0);
                chk("rst_idle", int'(tx_idle), 1);
                bc = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            bc = 1'b0;
            repeat (HP / 2) @(negedge clk);
            b[k] = ps2d_in;
            if (k == glitch_k) begin
                bc = 1'b1;
                repeat (FL - 1) @(negedge clk);
                bc = 1'b0;
            end
            if (k == wr_k) begin
                din    = 8'hAA;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        end
        obs_q.push_back(b);
        repeat (HP / 2) @(negedge clk);
        if (ack_low)
            bd = 1'b1;
        repeat (HP / 2) @(negedge clk);
        bc = 1'b1;
        repeat (HP) @(negedge clk);
        bc = 1'b0;
        repeat (HP / 2) @(negedge clk);
        bd = 1'b0;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
        chk("ack_hold", int'(ack_err), int'(last_ack));
    endtask

    initial begin
        int cnt;
        logic [7:0] rd;
        bit al;
        repeat (3) @(negedge clk);
        chk("reset_c_oe", int'(ps2c_oe), 0);
        chk("reset_d_oe", int'(ps2d_oe), 0);
        chk("reset_idle", int'(tx_idle), 1);
        chk("reset_done", int'(tx_done_tick), 0);
        chk("reset_ack", int'(ack_err), 0);
        chk("reset_to", int'(timeout_err), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        issue(8'hF4, 1'b0, 1'b0);
        device(1'b1, 0, 0, 0);
        settle();

        issue(8'h00, 1'b1, 1'b0);
        device(1'b0, 0, 0, 0);
        settle();

        issue(8'hED, 1'b0, 1'b0);
        device(1'b1, 0, 0, 2);
        settle();

        issue(8'h5A, 1'b0, 1'b0);
        device(1'b1, 4, 0, 0);
        settle();

        issue(8'h3C, 1'b0, 1'b1);
        cnt = 0;
        while (!tx_done_tick && cnt < RTS + TO + 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!tx_done_tick)
            expire("timeout_done");
        chk("timeout_latency_ok",
            int'(cnt >= RTS + TO - 1 && cnt <= RTS + TO + 1), 1);
        @(negedge clk);
        chk("to_c_oe", int'(ps2c_oe), 0);
        chk("to_d_oe", int'(ps2d_oe), 0);
        chk("to_idle", int'(tx_idle), 1);
        chk("to_hold", int'(timeout_err), 1);

        issue(8'hF4, 1'b0, 1'b0);
        device(1'b1, 0, 4, 0);
        void'(exp_q.pop_back());
        last_ack = 1'b0;
        settle();
        issue(8'hF4, 1'b0, 1'b0);
        device(1'b1, 0, 0, 0);
        settle();

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            al = 1'($urandom_range(0, 1));
            issue(rd, !al, 1'b0);
            device(al, 0, 0, 0);
            settle();
        end

        repeat (10) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("obs_q_empty", obs_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
